// File: rtl/mac_pkg.sv
// Shared widths, FSM encoding and operand-extension helper for the mac_acc slice.
package mac_pkg;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int SUM_W     = 20;
  localparam int MAX_TERMS = 16;
  localparam int MAX_DOTS  = 2048;
  localparam int TERM_W    = $clog2(MAX_TERMS);
  localparam int DOT_W     = $clog2(MAX_DOTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widen a product to accumulator width; sign-extends only when sgn is set.
  function automatic logic [SUM_W-1:0] ext_prod(input logic [PROD_W-1:0] p, input logic sgn);
    return {{(SUM_W-PROD_W){sgn & p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/mac_mul.sv
// Stage 1 of the MAC pipeline: registered product plus last-term tag.
// MAC_ACC_SIGNED_EN selects two's-complement operands; default is unsigned.
module mac_mul
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              last_in,
  input  logic [OP_W-1:0]   a_data,
  input  logic [OP_W-1:0]   b_data,
  output logic [PROD_W-1:0] prod_q,
  output logic              vld_q,
  output logic              last_q
);

  logic [PROD_W-1:0] prod_d;
  logic              vld_d;
  logic              last_d;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;

  always_comb begin
`ifdef MAC_ACC_SIGNED_EN
    a_ext = {{(PROD_W-OP_W){a_data[OP_W-1]}}, a_data};
    b_ext = {{(PROD_W-OP_W){b_data[OP_W-1]}}, b_data};
`else
    a_ext = {{(PROD_W-OP_W){1'b0}}, a_data};
    b_ext = {{(PROD_W-OP_W){1'b0}}, b_data};
`endif
    prod_d = prod_q;
    if (accept) prod_d = a_ext * b_ext;
    vld_d  = accept;
    last_d = accept & last_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mac_acc.sv
// Dot-product accumulator: run sequencing, term/dot counters and stage-2 accumulate.
// MAC_ACC_SIGNED_EN switches to two's-complement arithmetic; default build is unsigned.
//
// state | meaning
// IDLE  | waiting for start, beats ignored
// RUN   | accepting beats until K_TERMS*N_DOTS have been taken
// DRAIN | no more beats; waiting for the final web to leave the pipeline
// DONE  | one-cycle done pulse, start ignored
module mac_acc
  import mac_pkg::*;
#(
  parameter int K_TERMS = 8,
  parameter int N_DOTS  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  a_data,
  input  logic [OP_W-1:0]  b_data,
  output logic [SUM_W-1:0] sum,
  output logic             web,
  output logic             busy,
  output logic             done
);

`ifdef MAC_ACC_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [TERM_W-1:0]  term_q, term_d;
  logic [DOT_W-1:0]   dot_q, dot_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               web_q, web_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               last_term;
  logic               last_dot;
  logic [PROD_W-1:0]  prod;
  logic               prod_vld;
  logic               prod_last;
  logic [SUM_W-1:0]   prod_ext;

  assign accept    = (state_q == RUN) && in_valid;
  assign last_term = (term_q == TERM_W'(K_TERMS - 1));
  assign last_dot  = (dot_q == DOT_W'(N_DOTS - 1));

  mac_mul u_mul (
    .clk     (clk),
    .rst     (rst),
    .accept  (accept),
    .last_in (last_term),
    .a_data  (a_data),
    .b_data  (b_data),
    .prod_q  (prod),
    .vld_q   (prod_vld),
    .last_q  (prod_last)
  );

  assign prod_ext = ext_prod(prod, SIGNED_EN);

  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    dot_d   = dot_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          term_d  = '0;
          dot_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_term) begin
            term_d = '0;
            if (last_dot) begin
              dot_d   = '0;
              state_d = DRAIN;
            end else begin
              dot_d = dot_q + DOT_W'(1);
            end
          end else begin
            term_d = term_q + TERM_W'(1);
          end
        end
      end
      // An older web can still be visible here when K_TERMS is 1, so also
      // require stage 1 to be empty before declaring the run finished.
      DRAIN:   if (web_q && !prod_vld) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    acc_d = acc_q;
    sum_d = sum_q;
    web_d = 1'b0;
    if (prod_vld) begin
      if (prod_last) begin
        sum_d = acc_q + prod_ext;
        acc_d = '0;
        web_d = 1'b1;
      end else begin
        acc_d = acc_q + prod_ext;
      end
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      term_q  <= '0;
      dot_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      web_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      dot_q   <= dot_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      web_q   <= web_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign web  = web_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mac_acc.sv
// Three mac_acc instances (K/N = 4/3, 1/5, 16/1) sharing operand inputs, each with its own start.
module tb_mac_acc;

  localparam int K0 = 4;
  localparam int N0 = 3;
  localparam int K1 = 1;
  localparam int N1 = 5;
  localparam int K2 = 16;
  localparam int N2 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = 3'b000;
  logic        in_valid = 1'b0;
  logic [7:0]  a_data = 8'd0;
  logic [7:0]  b_data = 8'd0;
  logic [19:0] sum_o  [3];
  logic        web_o  [3];
  logic        busy_o [3];
  logic        done_o [3];

  always #5 clk = ~clk;

  mac_acc #(.K_TERMS(K0), .N_DOTS(N0)) u_d0 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .a_data(a_data), .b_data(b_data),
    .sum(sum_o[0]), .web(web_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  mac_acc #(.K_TERMS(K1), .N_DOTS(N1)) u_d1 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .a_data(a_data), .b_data(b_data),
    .sum(sum_o[1]), .web(web_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  mac_acc #(.K_TERMS(K2), .N_DOTS(N2)) u_d2 (
    .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .a_data(a_data), .b_data(b_data),
    .sum(sum_o[2]), .web(web_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  typedef struct {
    int          d;
    int          e;
    logic [19:0] s;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   n = 0;
  int   kk [3];
  int   nn [3];
  exp_t q [$];

  // Reference: expected behaviour of each instance, tracked per edge index n.
  bit          m_run  [3];
  int          m_terms[3];
  int          m_dots [3];
  int          m_acc  [3];
  int          done_edge [3];
  bit          e_busy [3];
  bit          e_done [3];
  bit          e_web  [3];
  logic [19:0] e_sum  [3];

  task automatic chk(input string tag, input int d, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d edge=%0d observed=%0d expected=%0d", tag, d, n, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int d = 0; d < 3; d++) begin
      m_run[d] = 1'b0; m_terms[d] = 0; m_dots[d] = 0; m_acc[d] = 0;
      done_edge[d] = -1; e_busy[d] = 1'b0; e_done[d] = 1'b0; e_web[d] = 1'b0; e_sum[d] = '0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk("web",  d, 20'(web_o[d]),  20'(e_web[d]));
      chk("sum",  d, sum_o[d],       e_sum[d]);
      chk("busy", d, 20'(busy_o[d]), 20'(e_busy[d]));
      chk("done", d, 20'(done_o[d]), 20'(e_done[d]));
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] st);
    bit acc [3];
    bit sok [3];
    int prod;
    in_valid = v; a_data = a; b_data = b; start = st;
    for (int d = 0; d < 3; d++) begin
      acc[d] = m_run[d] && v;
      sok[d] = st[d] && !e_busy[d] && !e_done[d];
    end
`ifdef MAC_ACC_SIGNED_EN
    prod = int'($signed(a)) * int'($signed(b));
`else
    prod = int'(a) * int'(b);
`endif
    @(negedge clk);
    n++;
    for (int d = 0; d < 3; d++) begin
      e_web[d]  = 1'b0;
      e_done[d] = (n == done_edge[d]);
      if (e_done[d]) e_busy[d] = 1'b0;
      if (acc[d]) begin
        m_acc[d] += prod;
        m_terms[d]++;
        if (m_terms[d] == kk[d]) begin
          q.push_back('{d, n + 1, 20'(m_acc[d])});
          m_acc[d] = 0;
          m_terms[d] = 0;
          m_dots[d]--;
          if (m_dots[d] == 0) begin
            m_run[d] = 1'b0;
            done_edge[d] = n + 2;
          end
        end
      end
      if (sok[d]) begin
        m_run[d] = 1'b1; e_busy[d] = 1'b1;
        m_terms[d] = 0; m_acc[d] = 0; m_dots[d] = nn[d];
      end
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].e <= n) begin
        e_web[q[i].d] = (q[i].e == n);
        e_sum[q[i].d] = q[i].s;
        q.delete(i);
      end
    end
    check_all();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 8'd0, 8'd0, 3'b000);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; start = 3'b000;
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    n++;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] st;
    kk[0] = K0; kk[1] = K1; kk[2] = K2;
    nn[0] = N0; nn[1] = N1; nn[2] = N2;
    model_clear();

    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // K=4, N=3: a=1..12, b=1, continuous beats -> 10, 26, 42
    tick(1'b0, 8'd0, 8'd0, 3'b001);
    for (int i = 1; i <= 12; i++) tick(1'b1, 8'(i), 8'd1, 3'b000);
    idle(4);
    chk("sum_after_k4n3", 0, sum_o[0], 20'd42);

    // K=1, N=5: one web per beat
    tick(1'b0, 8'd0, 8'd0, 3'b010);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'b000);
    idle(4);

    // K=16 worst-case magnitude
    tick(1'b0, 8'd0, 8'd0, 3'b100);
`ifdef MAC_ACC_SIGNED_EN
    for (int i = 0; i < 16; i++) tick(1'b1, 8'h80, 8'h80, 3'b000);
    idle(4);
    chk("sum_k16_max", 2, sum_o[2], 20'd262144);
`else
    for (int i = 0; i < 16; i++) tick(1'b1, 8'd255, 8'd255, 3'b000);
    idle(4);
    chk("sum_k16_max", 2, sum_o[2], 20'd1040400);
`endif

    // in_valid toggling with a stray start mid-run
    tick(1'b0, 8'd0, 8'd0, 3'b001);
    for (int i = 0; i < 24; i++)
      tick(i % 2 == 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), (i == 7) ? 3'b001 : 3'b000);
    idle(4);

    // reset one cycle after the third beat of a K=4 dot product
    tick(1'b0, 8'd0, 8'd0, 3'b001);
    for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'b000);
    tick(1'b0, 8'd0, 8'd0, 3'b000);
    do_reset();
    idle(3);
    tick(1'b0, 8'd0, 8'd0, 3'b001);
    for (int i = 0; i < 12; i++) tick(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'b000);
    idle(4);

    // random mix across all instances
    for (int i = 0; i < 400; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      tick($urandom_range(0, 3) != 0, a, b, st);
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_acc.md
MAC_ACC -- requirements
Module: mac_acc

Interface
REQ-001 The block SHALL have parameter K_TERMS, default 8, giving products accumulated per dot product; legal range 1..16.
REQ-002 The block SHALL have parameter N_DOTS, default 64, giving dot products per run; legal range 1..2048.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a run.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a_data and b_data carry one operand pair this cycle.
REQ-007 The block SHALL have ports a_data and b_data, input, 8 bits each: operand pair.
REQ-008 The block SHALL have port sum, output, 20 bits: last completed dot product.
REQ-009 The block SHALL have port web, output, 1 bit: one-cycle write strobe to the downstream write-back stage; sum is valid in that cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last web of a run.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-013 IDLE->RUN on start; RUN->DRAIN when the (K_TERMS*N_DOTS)-th beat is accepted; DRAIN->DONE when the final web is issued; DONE->IDLE after one cycle.
REQ-014 Beats SHALL be accepted only in RUN with in_valid=1; in_valid in IDLE, DRAIN or DONE SHALL be ignored.
REQ-015 start while busy=1 or in DONE SHALL be ignored.
REQ-016 Stage 1 SHALL register the 16-bit product a_data*b_data, tagged with a last-term flag when the term counter equals K_TERMS-1.
REQ-017 Stage 2 SHALL add the registered product, zero-extended to 20 bits, into a 20-bit accumulator.
REQ-018 On a last-tagged product, stage 2 SHALL load sum with accumulator+product, clear the accumulator, and assert web for exactly that cycle.
REQ-019 Latency SHALL be fixed: web asserts exactly 2 cycles after the clock edge accepting the K_TERMS-th beat of a dot product.
REQ-020 Back-to-back dot products SHALL need no bubble: a first-term product arriving in the same cycle as the accumulator clear SHALL start from 0.
REQ-021 K_TERMS=1 SHALL give one web per accepted beat.
REQ-022 The result SHALL never overflow (16*255*255 = 1,040,400 < 2^20), so no saturation or wrap logic is required.
REQ-023 sum SHALL hold its value between web pulses.
REQ-024 The term counter SHALL wrap K_TERMS-1 -> 0.
REQ-025 The dot counter SHALL increment on each last-tagged beat.
REQ-026 done SHALL assert the cycle after the final web.

Reset
REQ-027 rst=1 SHALL force IDLE immediately and clear all outputs, counters, accumulator and pipeline flags to 0.
REQ-028 Reset mid-run SHALL abort the run with no web or done pulse issued after reset asserts.

Configuration
REQ-029 With MAC_ACC_SIGNED_EN defined, operands SHALL be two's-complement, the product sign-extended, and sum a two's-complement 20-bit value (range provably fits for K_TERMS<=16).
REQ-030 Without MAC_ACC_SIGNED_EN, all arithmetic SHALL be unsigned.

Structure
REQ-031 Package mac_pkg SHALL hold the operand width (8), product width (16), sum width (20), MAX_TERMS (16) and the FSM state encoding.
REQ-032 Sub-module mac_mul SHALL implement stage 1 (registered product plus last flag).
REQ-033 mac_acc SHALL instantiate mac_mul and own the FSM, counters and accumulator.

Verification
REQ-034 K=8, N=1, unsigned, all beats a=255, b=255 -> one web with sum=520200, done next cycle, busy low after.
REQ-035 K=4, N=3, continuous in_valid, a=1..12, b=1 -> web at 2 cycles after beats 4, 8 and 12 with sum=10, 26, 42, and no gap between dot products.
REQ-036 K=16, N=1, a=b=255 -> sum=1040400 exactly; with MAC_ACC_SIGNED_EN, a=b=-128 -> sum=262144.
REQ-037 in_valid toggling 1,0,1,0 during RUN, plus a start pulse mid-run -> only valid beats counted, start ignored, results match the model.
REQ-038 rst asserted 1 cycle after the 3rd beat of K=4 -> no web, all outputs 0 immediately; a new start then gives correct fresh sums.
REQ-039 K=1, N=5 -> five consecutive web pulses matching each a*b product.
